// File: rtl/gpu_addr_unpack_if.sv
// Handshake bundle for gpu_addr_unpack: address request in, (x, y, err) result out.
interface gpu_addr_unpack_if #(
  parameter int WIDTH_BITS  = 10,
  parameter int HEIGHT_BITS = 9,
  parameter int ADDR_BITS   = WIDTH_BITS + HEIGHT_BITS + 1
);
  logic [ADDR_BITS-1:0]   in_addr;
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH_BITS-1:0]  out_x;
  logic [HEIGHT_BITS-1:0] out_y;
  logic                   out_err;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    output in_addr, in_valid, out_ready,
    input  in_ready, out_x, out_y, out_err, out_valid
  );

  modport slave (
    input  in_addr, in_valid, out_ready,
    output in_ready, out_x, out_y, out_err, out_valid
  );
endinterface

// File: rtl/gpu_addr_unpack.sv
// Linear framebuffer address -> (x, y) via a restoring divider, one quotient bit per clock.
// Define GPU_UNPACK_BACK2BACK_EN to accept a new address on the edge that retires a result.
module gpu_addr_unpack #(
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int WIDTH_BITS  = 10,
  parameter int HEIGHT_BITS = 9,
  parameter int ADDR_BITS   = WIDTH_BITS + HEIGHT_BITS + 1
) (
  input  logic             clk,
  input  logic             rst,
  gpu_addr_unpack_if.slave bus
);

  localparam int REM_W = ADDR_BITS + 1;
  localparam int K_W   = $clog2(HEIGHT_BITS + 1);
  localparam logic [REM_W-1:0] DIVISOR = REM_W'(WIDTH);
  localparam logic [REM_W-1:0] LIMIT   = REM_W'(WIDTH * HEIGHT);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [REM_W-1:0]       rem_q, rem_d;
  logic [HEIGHT_BITS-1:0] quo_q, quo_d;
  logic [K_W-1:0]         k_q, k_d;
  logic [WIDTH_BITS-1:0]  x_q, x_d;
  logic [HEIGHT_BITS-1:0] y_q, y_d;
  logic                   err_q, err_d;
  logic                   vld_q, vld_d;

  logic                   in_ready;
  logic                   accept;
  logic [REM_W:0]         step;
  logic [HEIGHT_BITS-1:0] quo_nx;

  // One restoring step: {quotient bit, updated remainder}; the shifted divisor is kept at full width.
  function automatic logic [REM_W:0] div_step(input logic [REM_W-1:0] rem,
                                              input logic [K_W-1:0]   k);
    logic [REM_W-1:0] shifted;
    shifted = DIVISOR << k;
    if (rem >= shifted) return {1'b1, rem - shifted};
    return {1'b0, rem};
  endfunction

`ifdef GPU_UNPACK_BACK2BACK_EN
  assign in_ready = (state_q == S_IDLE) | ((state_q == S_DONE) & bus.out_ready);
`else
  assign in_ready = (state_q == S_IDLE);
`endif

  assign accept = bus.in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    k_d     = k_q;
    x_d     = x_q;
    y_d     = y_q;
    err_d   = err_q;
    vld_d   = vld_q;
    step    = div_step(rem_q, k_q);
    quo_nx  = quo_q;
    quo_nx[k_q] = step[REM_W];

    case (state_q)
      S_DIV: begin
        rem_d = step[REM_W-1:0];
        quo_d = quo_nx;
        if (k_q == '0) begin
          state_d = S_DONE;
          vld_d   = 1'b1;
          err_d   = 1'b0;
          y_d     = quo_nx;
          x_d     = step[WIDTH_BITS-1:0];
        end else begin
          k_d = k_q - K_W'(1);
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
          vld_d   = 1'b0;
        end
      end
      default: ;
    endcase

    // A new request overrides the retire path above when both land on one edge.
    if (accept) begin
      rem_d = {1'b0, bus.in_addr};
      quo_d = '0;
      if ({1'b0, bus.in_addr} >= LIMIT) begin
        state_d = S_DONE;
        vld_d   = 1'b1;
        err_d   = 1'b1;
        x_d     = '0;
        y_d     = '0;
      end else begin
        state_d = S_DIV;
        vld_d   = 1'b0;
        k_d     = K_W'(HEIGHT_BITS - 1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      k_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      k_q     <= k_d;
      x_q     <= x_d;
      y_q     <= y_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_x     = x_q;
  assign bus.out_y     = y_q;
  assign bus.out_err   = err_q;
  assign bus.out_valid = vld_q;

endmodule
